// File: rtl/fpu_mul_arbiter.sv
// ============================================================================
// Module   : fpu_mul_arbiter
// Brief    : Round-robin arbiter sharing one 16-bit-bus multiplier among
//            NUM_REQ requesters. Optional stall watchdog: FPU_ARB_WDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpu_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_z,
    output logic                    resp_err,
    input  logic [NUM_REQ-1:0]      resp_ack,
    output logic                    mul_rst,
    output logic [15:0]             mul_a,
    output logic [15:0]             mul_b,
    output logic                    mul_a_stb,
    output logic                    mul_b_stb,
    input  logic                    mul_a_ack,
    input  logic                    mul_b_ack,
    input  logic [15:0]             mul_z,
    input  logic                    mul_z_stb,
    output logic                    mul_z_ack
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_param_check
        $error("fpu_mul_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_A_HI = 3'd1,
        S_SEND_A_LO = 3'd2,
        S_SEND_B_HI = 3'd3,
        S_SEND_B_LO = 3'd4,
        S_RECV_Z_HI = 3'd5,
        S_RECV_Z_LO = 3'd6,
        S_RESPOND   = 3'd7
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_last, w_last_nxt, r_gnt, w_gnt_nxt;
    logic [31:0]        r_a, w_a_nxt, r_b, w_b_nxt, r_z, w_z_nxt;
    logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt, r_resp_valid, w_resp_valid_nxt;
    logic [15:0]        r_mul_a, w_mul_a_nxt, r_mul_b, w_mul_b_nxt;
    logic               r_a_stb, w_a_stb_nxt, r_b_stb, w_b_stb_nxt, r_z_ack, w_z_ack_nxt;

    logic [31:0]        w_a_arr [NUM_REQ];
    logic [31:0]        w_b_arr [NUM_REQ];
    logic               w_found;
    logic [IW-1:0]      w_gidx;
    logic               w_xfer_a, w_xfer_b, w_xfer_z;

    assign w_xfer_a = r_a_stb & mul_a_ack;
    assign w_xfer_b = r_b_stb & mul_b_ack;
    assign w_xfer_z = r_z_ack & mul_z_stb;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_a_arr[i] = req_a[32*i +: 32];
            w_b_arr[i] = req_b[32*i +: 32];
        end
    end

    // Walk downward so the last hit is the nearest index after r_last.
    always_comb begin
        logic [IW-1:0] v_idx;
        w_found = 1'b0;
        w_gidx  = r_last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = IW'((int'(r_last) + k) % NUM_REQ);
            if (req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gidx  = v_idx;
            end
        end
    end

`ifdef FPU_ARB_WDOG_EN
    logic [15:0] r_wdog, w_wdog_nxt;
    logic        r_resp_err, w_err_nxt, r_wdog_rst, w_wdog_rst_nxt;
    logic        w_stall_st;

    assign w_stall_st = (r_state != S_IDLE) && (r_state != S_RESPOND);
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_gnt_nxt        = r_gnt;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_z_nxt          = r_z;
        w_req_ready_nxt  = '0;
        w_resp_valid_nxt = r_resp_valid;
        w_mul_a_nxt      = r_mul_a;
        w_mul_b_nxt      = r_mul_b;
        w_a_stb_nxt      = r_a_stb;
        w_b_stb_nxt      = r_b_stb;
        w_z_ack_nxt      = r_z_ack;
        case (r_state)
            S_IDLE: if (w_found) begin
                w_gnt_nxt               = w_gidx;
                w_a_nxt                 = w_a_arr[w_gidx];
                w_b_nxt                 = w_b_arr[w_gidx];
                w_req_ready_nxt[w_gidx] = 1'b1;
                w_a_stb_nxt             = 1'b1;
                w_mul_a_nxt             = w_a_arr[w_gidx][31:16];
                w_state_nxt             = S_SEND_A_HI;
            end
            S_SEND_A_HI: if (w_xfer_a) begin
                w_mul_a_nxt = r_a[15:0];
                w_state_nxt = S_SEND_A_LO;
            end
            S_SEND_A_LO: if (w_xfer_a) begin
                w_a_stb_nxt = 1'b0;
                w_b_stb_nxt = 1'b1;
                w_mul_b_nxt = r_b[31:16];
                w_state_nxt = S_SEND_B_HI;
            end
            S_SEND_B_HI: if (w_xfer_b) begin
                w_mul_b_nxt = r_b[15:0];
                w_state_nxt = S_SEND_B_LO;
            end
            S_SEND_B_LO: if (w_xfer_b) begin
                w_b_stb_nxt = 1'b0;
                w_z_ack_nxt = 1'b1;
                w_state_nxt = S_RECV_Z_HI;
            end
            S_RECV_Z_HI: if (w_xfer_z) begin
                w_z_nxt[31:16] = mul_z;
                w_state_nxt    = S_RECV_Z_LO;
            end
            S_RECV_Z_LO: if (w_xfer_z) begin
                w_z_nxt[15:0]           = mul_z;
                w_z_ack_nxt             = 1'b0;
                w_resp_valid_nxt        = '0;
                w_resp_valid_nxt[r_gnt] = 1'b1;
                w_state_nxt             = S_RESPOND;
            end
            S_RESPOND: if (resp_ack[r_gnt]) begin
                w_resp_valid_nxt = '0;
                w_last_nxt       = r_gnt;
                w_state_nxt      = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef FPU_ARB_WDOG_EN
        w_err_nxt      = r_resp_err;
        w_wdog_rst_nxt = 1'b0;
        if (r_state == S_RESPOND && resp_ack[r_gnt])
            w_err_nxt = 1'b0;
        // Only a cycle with no progress counts toward the limit.
        if (w_stall_st && w_state_nxt == r_state && r_wdog == 16'(WDOG_CYCLES - 1)) begin
            w_a_stb_nxt             = 1'b0;
            w_b_stb_nxt             = 1'b0;
            w_z_ack_nxt             = 1'b0;
            w_z_nxt                 = 32'h7FC0_0000;
            w_resp_valid_nxt        = '0;
            w_resp_valid_nxt[r_gnt] = 1'b1;
            w_err_nxt               = 1'b1;
            w_wdog_rst_nxt          = 1'b1;
            w_state_nxt             = S_RESPOND;
        end
        w_wdog_nxt = (w_stall_st && w_state_nxt == r_state) ? r_wdog + 16'd1 : 16'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last       <= IW'(NUM_REQ - 1);
            r_gnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_z          <= '0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_a_stb      <= 1'b0;
            r_b_stb      <= 1'b0;
            r_z_ack      <= 1'b0;
`ifdef FPU_ARB_WDOG_EN
            r_wdog       <= '0;
            r_resp_err   <= 1'b0;
            r_wdog_rst   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_gnt        <= w_gnt_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_z          <= w_z_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_mul_a      <= w_mul_a_nxt;
            r_mul_b      <= w_mul_b_nxt;
            r_a_stb      <= w_a_stb_nxt;
            r_b_stb      <= w_b_stb_nxt;
            r_z_ack      <= w_z_ack_nxt;
`ifdef FPU_ARB_WDOG_EN
            r_wdog       <= w_wdog_nxt;
            r_resp_err   <= w_err_nxt;
            r_wdog_rst   <= w_wdog_rst_nxt;
`endif
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_z     = r_z;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_a_stb  = r_a_stb;
    assign mul_b_stb  = r_b_stb;
    assign mul_z_ack  = r_z_ack;
`ifdef FPU_ARB_WDOG_EN
    assign resp_err   = r_resp_err;
    assign mul_rst    = rst | r_wdog_rst;
`else
    assign resp_err   = 1'b0;
    assign mul_rst    = rst;
`endif

endmodule

`default_nettype wire

// File: doc/fpu_mul_arbiter.md
# fpu_mul_arbiter

Shares one 16-bit-bus single-precision multiplier between `NUM_REQ` requesters. Each requester submits a full 32-bit operand pair in one transfer. The arbiter grants requesters round-robin, serialises the operands into the multiplier's word-wise stb/ack protocol, and collects the two result words. It then returns the 32-bit product to the granted requester. It sits between the multiplier and its clients in the FPU cluster.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WDOG_CYCLES`, 255: stall limit for the watchdog, 1..65535. Used only when `FPU_ARB_WDOG_EN` is defined.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_a`, `req_b`  in  32*NUM_REQ  operands; requester i occupies bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-cycle registered accept pulse.
- `resp_valid`  out  NUM_REQ  result available for requester i.
- `resp_z`  out  32  result, shared by all requesters.
- `resp_err`  out  1  result came from a watchdog abort.
- `resp_ack`  in  NUM_REQ  requester consumes its result.
- `mul_rst`  out  1  multiplier reset.
- `mul_a`, `mul_b`  out  16  operand words to the multiplier.
- `mul_a_stb`, `mul_b_stb`  out  1  operand word strobes.
- `mul_a_ack`, `mul_b_ack`  in  1  multiplier operand acknowledges.
- `mul_z`  in  16  result word from the multiplier.
- `mul_z_stb`  in  1  result word strobe.
- `mul_z_ack`  out  1  result word acknowledge.

## Operation
- A word moves on any rising edge where stb and ack are both 1. Each operand and result is sent high word first, then low word.
- State machine: IDLE → SEND_A_HI → SEND_A_LO → SEND_B_HI → SEND_B_LO → RECV_Z_HI → RECV_Z_LO → RESPOND → IDLE.
- IDLE, grant: pick the first `req_valid` bit searching upward, with wrap, from `last+1`. `last` is the most recently granted index and resets to NUM_REQ-1.
- IDLE, on the grant edge:
  - Capture that requester's a and b.
  - Register `req_ready[g]`=1 for exactly one cycle.
  - Go to SEND_A_HI with `mul_a_stb`=1 and `mul_a`=a[31:16].
- SEND_A_HI: on its transfer edge, `mul_a` becomes a[15:0] and `mul_a_stb` stays 1.
- SEND_A_LO: on its transfer edge, `mul_a_stb`=0, `mul_b_stb`=1, `mul_b`=b[31:16]. The B states mirror the A states.
- After the B low-word transfer, `mul_b_stb`=0 and `mul_z_ack`=1.
- RECV_Z_HI and RECV_Z_LO capture `mul_z` into z[31:16] then z[15:0]. `mul_z_ack` drops on the edge that leaves RECV_Z_LO.
- RESPOND: `resp_valid[g]`=1 and `resp_z`=z, held until `resp_ack[g]`=1 is sampled. On that edge `resp_valid` clears, `last`=g, and the state returns to IDLE.
- `resp_ack` bits for non-granted indices are ignored. `req_valid` is sampled only in IDLE.
- Requester rule: on the edge where `req_ready` is high, the requester must drop `req_valid` or present new operands.
- Exactly one operation is in flight at a time; there is no operand buffering.
- Results pass through unmodified. Special cases (NaN, inf, zero) are the multiplier's responsibility.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_z`=0, `resp_err`=0, all strobes and `mul_z_ack`=0, `mul_a`=`mul_b`=0, state=IDLE, `last`=NUM_REQ-1.
- `mul_rst`=1 during `rst`. An `rst` in any state abandons the operation without issuing a response, and the multiplier is reset with it.
- Grant: 1 cycle after the first `req_valid` sample in IDLE.
- Each word transfer takes ≥1 cycle per side. The multiplier's registered ack gives ≥2 cycles per word.
- A back-to-back grant is possible on the edge after `resp_ack`, because IDLE samples on the next edge.
- Simultaneous `req_valid` and a stalled `resp_ack`: new requests wait. Fairness is still guaranteed by the `last` pointer.

## Configuration
- `FPU_ARB_WDOG_EN` defined:
  - A stall counter clears on every state change and counts in SEND_* and RECV_* states.
  - When the counter reaches `WDOG_CYCLES`:
    - Pulse `mul_rst` for one cycle.
    - Clear all strobes and `mul_z_ack`.
    - Set z=32'h7FC00000 and `resp_err`=1.
    - Enter RESPOND.
  - `resp_err` clears when the response is acknowledged.
- `FPU_ARB_WDOG_EN` undefined: no counter, `resp_err` tied 0, `mul_rst`=`rst`. The block waits on the multiplier indefinitely.

## Test plan
- Single requester, index 0: a=0x40000000, b=0x40400000 → `req_ready[0]` pulse, then `resp_valid[0]` with `resp_z`=0x40C00000 and `resp_err`=0.
- Requesters 0, 1, 2 all valid from reset, acks immediate → grant order 0, 1, 2. If 0 re-requests after its response, the next grant is 1 or 2 before 0 again.
- `resp_ack` withheld 20 cycles → `resp_valid` and `resp_z` held stable, no new grant, and `mul_a_stb` stays 0.
- `rst` asserted while in RECV_Z_HI → all outputs return to reset values the next cycle, no response is issued, and a following request completes correctly.
- Multiplier `mul_b_ack` forced low, with `FPU_ARB_WDOG_EN` and `WDOG_CYCLES`=10 → after 10 stalled cycles, `mul_rst` pulses and the response is 0x7FC00000 with `resp_err`=1.
- Word-order check: a=0x3F800000, b=0xC0000000 → multiplier sees words 0x3F80, 0x0000, 0xC000, 0x0000 in that order, and `resp_z`=0xC0000000.
